// File: rtl/regs_wr_sched_pkg.sv
// regs_wr_sched_pkg: shared state encoding and register-file geometry
package regs_wr_sched_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam int REG_COUNT = 8;
  localparam int REG_AW = 3;
endpackage

// File: rtl/regs_wr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);
  // scan offsets from farthest to nearest so the nearest requester above ptr wins
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) win = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/regs_wr_sched.sv
// regs_wr_sched: round-robin write-port scheduler with hardware clear sweep
module regs_wr_sched
  import regs_wr_sched_pkg::*;
#(
  parameter int N = 3,
  parameter int DEPTH = REG_COUNT,
  parameter int AW = REG_AW,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            cr,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    gnt,
  input  logic            clr_start,
  output logic            busy,
  output logic            clr_done,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [DW-1:0]   rf_di
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t r_state, w_state_nx;
  logic [PW-1:0] r_ptr, w_ptr_nx, w_idx;
  logic [AW-1:0] r_cnt, w_cnt_nx, w_addr_nx;
  logic [N-1:0] w_elig, w_win, w_gnt_nx;
  logic [DW-1:0] w_di_nx;
  logic w_we_nx, w_busy_nx, w_done_nx;
  // a requester granted this cycle is still dropping req, so it sits out this edge
  assign w_elig = req & ~gnt;
  rr_arbiter #(.N(N), .PW(PW)) u_arb (.req(w_elig), .ptr(r_ptr), .win(w_win));
  // one-hot winner to index for the data mux and pointer update
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) if (w_win[i]) w_idx = PW'(i);
  end
  // next state and next registered outputs; r_cnt holds the sweep address on rf_addr
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx = r_ptr;
    w_cnt_nx = r_cnt;
    w_gnt_nx = '0;
    w_we_nx = 1'b0;
    w_addr_nx = '0;
    w_di_nx = '0;
    w_busy_nx = 1'b0;
    w_done_nx = 1'b0;
    if (r_state == IDLE) begin
      if (clr_start) begin
        w_state_nx = SWEEP;
        w_cnt_nx = '0;
        w_we_nx = 1'b1;
        w_busy_nx = 1'b1;
        w_done_nx = (LAST == '0);
      end else if (|w_win) begin
        w_gnt_nx = w_win;
        w_we_nx = 1'b1;
        w_addr_nx = req_addr[w_idx*AW +: AW];
        w_di_nx = req_data[w_idx*DW +: DW];
        w_ptr_nx = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
    end else if (r_cnt == LAST) begin
      w_state_nx = IDLE;
      w_cnt_nx = '0;
    end else begin
      w_cnt_nx = r_cnt + 1'b1;
      w_we_nx = 1'b1;
      w_addr_nx = w_cnt_nx;
      w_busy_nx = 1'b1;
      w_done_nx = (w_cnt_nx == LAST);
    end
  end
  // state, pointer, counter and all outputs registered; reset clears everything at once
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      gnt <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_di <= '0;
      busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr <= w_ptr_nx;
      r_cnt <= w_cnt_nx;
      gnt <= w_gnt_nx;
      rf_we <= w_we_nx;
      rf_addr <= w_addr_nx;
      rf_di <= w_di_nx;
      busy <= w_busy_nx;
      clr_done <= w_done_nx;
    end
  end
endmodule

// File: tb/tb_regs_wr_sched.sv
// tb_regs_wr_sched: directed stimulus checked against a behavioural scheduler model
module tb_regs_wr_sched;
  localparam int N = 3;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int DW = 32;
  logic clk = 0;
  logic cr = 0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic clr_start = 0;
  logic [N-1:0] gnt;
  logic busy, clr_done, rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_di;
  int checks = 0;
  int errors = 0;
  bit run = 0;
  logic [N-1:0] e_gnt = '0;
  logic e_we = 0, e_busy = 0, e_done = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_di = '0;
  int m_ptr = 0;
  int m_left = 0;
  int w_pick;
  logic [DW-1:0] mem [DEPTH];

  regs_wr_sched #(.N(N), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .cr(cr), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_di(rf_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) if (elig[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // register file written by the DUT's write port
  always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_di;

  // reference: m_left counts sweep writes still owed plus one trailing idle cycle
  always_comb w_pick = rr_pick(req & ~e_gnt, m_ptr);
  always @(posedge clk or negedge cr) begin
    if (!cr) begin
      m_ptr <= 0; m_left <= 0; e_gnt <= '0; e_we <= 0; e_addr <= '0; e_di <= '0; e_busy <= 0; e_done <= 0;
    end else if (m_left == 1) begin
      m_left <= 0; e_gnt <= '0; e_we <= 0; e_addr <= '0; e_di <= '0; e_busy <= 0; e_done <= 0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1; e_gnt <= '0; e_we <= 1; e_addr <= AW'(DEPTH - m_left + 1);
      e_di <= '0; e_busy <= 1; e_done <= (m_left == 2);
    end else if (clr_start) begin
      m_left <= DEPTH; e_gnt <= '0; e_we <= 1; e_addr <= '0; e_di <= '0; e_busy <= 1; e_done <= (DEPTH == 1);
    end else if (w_pick >= 0) begin
      e_gnt <= N'(1) << w_pick; e_we <= 1; e_addr <= req_addr[w_pick*AW +: AW];
      e_di <= req_data[w_pick*DW +: DW]; e_busy <= 0; e_done <= 0; m_ptr <= (w_pick + 1) % N;
    end else begin
      e_gnt <= '0; e_we <= 0; e_addr <= '0; e_di <= '0; e_busy <= 0; e_done <= 0;
    end
  end

  // every cycle: all outputs against the model
  always @(negedge clk)
    if (run) chk("cycle {gnt,we,addr,di,busy,done}", {gnt, rf_we, rf_addr, rf_di, busy, clr_done},
                 {e_gnt, e_we, e_addr, e_di, e_busy, e_done});

  task automatic reset_pulse();
    @(negedge clk); #2 cr = 0;
    @(negedge clk); #2 cr = 1;
  endtask

  initial begin
    int nbusy, ndone;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("reset outputs", {gnt, rf_we, rf_addr, rf_di, busy, clr_done}, 64'd0);
    run = 1;
    #2 cr = 1;
    // single request
    @(negedge clk);
    req = 3'b001; req_addr[0 +: AW] = 3'd5; req_data[0 +: DW] = 32'hDEADBEEF;
    @(negedge clk);
    chk("single gnt", gnt, 3'b001);
    chk("single we", rf_we, 1);
    chk("single addr", rf_addr, 5);
    chk("single di", rf_di, 32'hDEADBEEF);
    req = '0;
    @(negedge clk);
    chk("single we after", rf_we, 0);
    reset_pulse();
    // fairness with all three requesting
    req_addr = {3'd3, 3'd2, 3'd1};
    req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    @(negedge clk);
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fair gnt", gnt, N'(1) << (i % 3));
      chk("fair we", rf_we, 1);
    end
    req = '0;
    @(negedge clk);
    chk("fair idle we", rf_we, 0);
    // clear sweep
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("sweep busy", busy, 1);
      chk("sweep addr", rf_addr, i);
      chk("sweep done", clr_done, i == DEPTH - 1);
      @(negedge clk);
    end
    chk("sweep busy fell", busy, 0);
    for (int i = 0; i < DEPTH; i++) chk("readback zero", mem[i], 0);
    // collision of clr_start and a request
    @(negedge clk);
    clr_start = 1; req = 3'b010;
    @(negedge clk);
    clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("collide gnt held", gnt, 0);
      @(negedge clk);
    end
    chk("collide drain", {busy, gnt}, 0);
    @(negedge clk);
    chk("collide gnt", gnt, 3'b010);
    req = '0;
    // reset mid-sweep
    @(negedge clk);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (3) @(negedge clk);
    #2 cr = 0;
    #1 chk("mid reset outputs", {gnt, rf_we, rf_addr, rf_di, busy, clr_done}, 64'd0);
    @(negedge clk); #2 cr = 1;
    @(negedge clk);
    chk("post reset idle", {rf_we, busy}, 0);
    req = 3'b100;
    @(negedge clk);
    chk("post reset gnt", gnt, 3'b100);
    req = '0;
    // clr_start re-pulsed mid-sweep is ignored
    @(negedge clk);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 12; i++) begin
      nbusy += int'(busy);
      ndone += int'(clr_done);
      clr_start = (i == 3);
      @(negedge clk);
    end
    chk("restart busy cycles", nbusy, 8);
    chk("restart done pulses", ndone, 1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
